// File: rtl/dozen_counter_datapath_pkg.sv
// Shared constants for the bottling-line dozen counter and its FSM.
// Provides units-per-dozen, units width and default batch size.
package dozen_counter_datapath_pkg;

   localparam int UNITS_PER_DOZEN = 12;
   localparam int UNITS_W         = 4;
   localparam int MAX_DOZENS_DEF  = 9;
   localparam int DOZENS_W_DEF    = 4;

   localparam logic [UNITS_W-1:0] UNITS_FULL =
      UNITS_W'(UNITS_PER_DOZEN);

endpackage

// File: rtl/dozen_counter_datapath_unit_counter_12.sv
// unit_counter_12: bottles-in-current-dozen register, saturating at 12.
// Ports: clk_i, reset_i (sync, active-high), inc_i, clr_i (clr wins),
//        units_o (0..12), cont12_o (units_o == 12, from the register).
module unit_counter_12
   import dozen_counter_datapath_pkg::*;
(
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               inc_i,
   input  logic               clr_i,
   output logic [UNITS_W-1:0] units_o,
   output logic               cont12_o
);

   logic [UNITS_W-1:0] units_q;
   logic [UNITS_W-1:0] units_d;

   always_comb begin
      units_d = units_q;
      if (clr_i) begin
         units_d = '0;
      end else if (inc_i && (units_q != UNITS_FULL)) begin
         units_d = units_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         units_q <= '0;
      end else begin
         units_q <= units_d;
      end
   end

   assign units_o  = units_q;
   assign cont12_o = (units_q == UNITS_FULL);

endmodule

// File: rtl/dozen_counter_datapath.sv
// Dozen-counter datapath: counts bottles into dozens, dozens into a batch.
// Ports: clk, reset (sync, active-high), cont1, add_cont12, clr_lote in;
//        cont12, units, dozens, lote_cheio, err out (all registered).
module dozen_counter_datapath
   import dozen_counter_datapath_pkg::*;
#(
   parameter int MAX_DOZENS = MAX_DOZENS_DEF,
   parameter int DW         = DOZENS_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cont1,
   input  logic               add_cont12,
   input  logic               clr_lote,
   output logic               cont12,
   output logic [UNITS_W-1:0] units,
   output logic [DW-1:0]      dozens,
   output logic               lote_cheio
,
   output logic               err
);

   localparam logic [DW-1:0] MAXD = DW'(MAX_DOZENS);

   logic [DW-1:0] dozens_q, dozens_d;
   logic          lote_q, lote_d;
   logic          err_q, err_d;
   logic          full;
   logic          fold;
   logic          inc;
   logic          viol;
   logic [DW-1:0] dozens_inc;

   assign full       = cont12;
   assign dozens_inc = dozens_q + 1'b1;

   // add_cont12 outranks cont1; a full batch freezes both counters.
   assign fold = add_cont12 && full && !lote_q;
   assign inc  = cont1 && !add_cont12 && !full && !lote_q;

   assign viol = (cont1 && (full || lote_q))
              || (add_cont12 && (!full || lote_q))
              || (cont1 && add_cont12);

   unit_counter_12 u_units (
      .clk_i    (clk),
      .reset_i  (reset),
      .inc_i    (inc),
      .clr_i    (fold),
      .units_o  (units),
      .cont12_o (cont12)
   );

   always_comb begin
      dozens_d = dozens_q;
      lote_d   = lote_q;
      err_d    = err_q;
      if (clr_lote) begin
         // A fold in this cycle still empties units but the dozen is dropped.
         dozens_d = '0;
         lote_d   = 1'b0;
         err_d    = 1'b0;
      end else begin
         if (fold && (dozens_q != MAXD)) begin
            dozens_d = dozens_inc;
            lote_d   = (dozens_inc == MAXD);
         end
         if (viol) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dozens_q <= '0;
         lote_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         dozens_q <= dozens_d;
         lote_q   <= lote_d;
         err_q    <= err_d;
      end
   end

   assign dozens     = dozens_q;
   assign lote_cheio = lote_q;
   assign err        = err_q;

endmodule

// File: tb/tb_dozen_counter_datapath.sv
// Directed testbench for dozen_counter_datapath.
// Drives stimulus 1ns after posedge and checks 1ns after the following edge.
module tb_dozen_counter_datapath;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cont1 = 1'b0;
   logic       add_cont12 = 1'b0;
   logic       clr_lote = 1'b0;
   logic       cont12;
   logic [3:0] units;
   logic [3:0] dozens;
   logic       lote_cheio;
   logic       err;

   int checks = 0;
   int errors = 0;

   dozen_counter_datapath dut (
      .clk        (clk),
      .reset      (reset),
      .cont1      (cont1),
      .add_cont12 (add_cont12),
      .clr_lote   (clr_lote),
      .cont12     (cont12),
      .units      (units),
      .dozens     (dozens),
      .lote_cheio (lote_cheio),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_cont1();
      cont1 = 1'b1;
      tick();
      cont1 = 1'b0;
      tick();
   endtask

   task automatic pulse_add();
      add_cont12 = 1'b1;
      tick();
      add_cont12 = 1'b0;
      tick();
   endtask

   task automatic full_dozen();
      for (int i = 0; i < 12; i++) pulse_cont1();
      pulse_add();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({units, dozens, cont12, lote_cheio, err} !== 11'd0) begin
         $display("FAIL reset: got u=%0d d=%0d c12=%b lc=%b e=%b want all 0",
                  units, dozens, cont12, lote_cheio, err);
         errors++;
      end
   endtask

   task automatic test_count_dozen();
      for (int i = 1; i <= 12; i++) begin
         cont1 = 1'b1;
         tick();
         cont1 = 1'b0;
         checks++;
         if (units !== 4'(i) || cont12 !== (i == 12)) begin
            $display("FAIL count%0d: got u=%0d c12=%b want u=%0d c12=%b",
                     i, units, cont12, i, (i == 12));
            errors++;
         end
         tick();
      end
      add_cont12 = 1'b1;
      tick();
      add_cont12 = 1'b0;
      checks++;
      if (units !== 4'd0 || dozens !== 4'd1 || cont12 !== 1'b0 || err !== 1'b0) begin
         $display("FAIL fold1: got u=%0d d=%0d c12=%b e=%b want 0 1 0 0",
                  units, dozens, cont12, err);
         errors++;
      end
   endtask

   task automatic test_batch_full();
      for (int k = 2; k <= 9; k++) begin
         full_dozen();
         checks++;
         if (dozens !== 4'(k) || lote_cheio !== (k == 9)) begin
            $display("FAIL batch%0d: got d=%0d lc=%b want d=%0d lc=%b",
                     k, dozens, lote_cheio, k, (k == 9));
            errors++;
         end
      end
      cont1 = 1'b1;
      tick();
      cont1 = 1'b0;
      checks++;
      if (units !== 4'd0 || err !== 1'b1 || dozens !== 4'd9) begin
         $display("FAIL full_cont1: got u=%0d e=%b d=%0d want 0 1 9",
                  units, err, dozens);
         errors++;
      end
   endtask

   task automatic test_bad_add();
      do_reset();
      for (int i = 0; i < 5; i++) pulse_cont1();
      add_cont12 = 1'b1;
      tick();
      add_cont12 = 1'b0;
      checks++;
      if (units !== 4'd5 || dozens !== 4'd0 || err !== 1'b1) begin
         $display("FAIL bad_add: got u=%0d d=%0d e=%b want 5 0 1",
                  units, dozens, err);
         errors++;
      end
      tick();
      clr_lote = 1'b1;
      tick();
      clr_lote = 1'b0;
      checks++;
      if (units !== 4'd5 || err !== 1'b0) begin
         $display("FAIL clr_err: got u=%0d e=%b want 5 0", units, err);
         errors++;
      end
   endtask

   task automatic test_same_cycle();
      for (int i = 0; i < 7; i++) pulse_cont1();
      checks++;
      if (units !== 4'd12 || cont12 !== 1'b1) begin
         $display("FAIL pre_same: got u=%0d c12=%b want 12 1", units, cont12);
         errors++;
      end
      cont1 = 1'b1;
      add_cont12 = 1'b1;
      tick();
      cont1 = 1'b0;
      add_cont12 = 1'b0;
      checks++;
      if (units !== 4'd0 || dozens !== 4'd1 || err !== 1'b1 || cont12 !== 1'b0) begin
         $display("FAIL same_cycle: got u=%0d d=%0d e=%b c12=%b want 0 1 1 0",
                  units, dozens, err, cont12);
         errors++;
      end
      tick();
   endtask

   task automatic test_saturate();
      clr_lote = 1'b1;
      tick();
      clr_lote = 1'b0;
      full_dozen();
      checks++;
      if (dozens !== 4'd1 || err !== 1'b0) begin
         $display("FAIL sat_setup: got d=%0d e=%b want 1 0", dozens, err);
         errors++;
      end
      for (int i = 0; i < 12; i++) pulse_cont1();
      cont1 = 1'b1;
      tick();
      cont1 = 1'b0;
      checks++;
      if (units !== 4'd12 || cont12 !== 1'b1 || err !== 1'b1) begin
         $display("FAIL 13th: got u=%0d c12=%b e=%b want 12 1 1",
                  units, cont12, err);
         errors++;
      end
      add_cont12 = 1'b1;
      tick();
      tick();
      tick();
      add_cont12 = 1'b0;
      checks++;
      if (units !== 4'd0 || dozens !== 4'd2 || cont12 !== 1'b0) begin
         $display("FAIL held_add: got u=%0d d=%0d c12=%b want 0 2 0",
                  units, dozens, cont12);
         errors++;
      end
      tick();
   endtask

   task automatic test_clr_with_fold();
      for (int i = 0; i < 12; i++) pulse_cont1();
      clr_lote = 1'b1;
      add_cont12 = 1'b1;
      tick();
      clr_lote = 1'b0;
      add_cont12 = 1'b0;
      checks++;
      if (units !== 4'd0 || dozens !== 4'd0 || err !== 1'b0) begin
         $display("FAIL clr_fold: got u=%0d d=%0d e=%b want 0 0 0",
                  units, dozens, err);
         errors++;
      end
      tick();
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int k = 0; k < 3; k++) full_dozen();
      for (int i = 0; i < 7; i++) pulse_cont1();
      checks++;
      if (units !== 4'd7 || dozens !== 4'd3) begin
         $display("FAIL pre_reset: got u=%0d d=%0d want 7 3", units, dozens);
         errors++;
      end
      do_reset();
      checks++;
      if ({units, dozens, cont12, lote_cheio, err} !== 11'd0) begin
         $display("FAIL mid_reset: got u=%0d d=%0d c12=%b lc=%b e=%b want all 0",
                  units, dozens, cont12, lote_cheio, err);
         errors++;
      end
      for (int k = 0; k < 4; k++) full_dozen();
      for (int i = 0; i < 3; i++) pulse_cont1();
      clr_lote = 1'b1;
      tick();
      clr_lote = 1'b0;
      checks++;
      if (dozens !== 4'd0 || units !== 4'd3 || lote_cheio !== 1'b0) begin
         $display("FAIL clr_batch: got d=%0d u=%0d lc=%b want 0 3 0",
                  dozens, units, lote_cheio);
         errors++;
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_count_dozen();
      test_batch_full();
      test_bad_add();
      test_same_cycle();
      test_saturate();
      test_clr_with_fold();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
